// File: rtl/shift_right_iter.sv
// shift_right_iter: iterative one-bit-per-cycle right shifter with logical or arithmetic fill
module shift_right_iter #(
  parameter int M = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [M-1:0] i_argA,
  input  logic [M-1:0] i_argB,
  input  logic         i_arith,
  output logic [M-1:0] o_y,
  output logic         o_busy,
  output logic         o_done,
  output logic         ERROR
);
  localparam int CW = $clog2(M) + 1;
  localparam logic [M-1:0] MV = M'(M);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [M-1:0] w;
  logic [M-1:0] shifted;
  logic [CW-1:0] cnt;
  logic [CW-1:0] k;
  logic fill;
  // Shift amount saturated to M, and the working value after one more shift step
  always_comb begin
    k = (i_argB >= MV) ? CW'(M) : CW'(i_argB);
    shifted = {fill, w[M-1:1]};
  end
  // Control FSM with registered outputs; shifts one bit per SHIFT cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      w <= '0;
      fill <= 1'b0;
      cnt <= '0;
      o_y <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      ERROR <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            w <= i_argA;
            fill <= i_arith & i_argA[M-1];
            ERROR <= i_argB[M-1];
            o_busy <= 1'b1;
            if (i_argB[M-1]) begin
              o_y <= '0;
              o_done <= 1'b1;
              state <= DONE;
            end else if (k == '0) begin
              o_y <= i_argA;
              o_done <= 1'b1;
              state <= DONE;
            end else begin
              cnt <= k;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          w <= shifted;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            o_y <= shifted;
            o_done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state <= IDLE;
        end
        default: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shift_right_iter.sv
// tb_shift_right_iter: scoreboard bench for the iterative right shifter
module tb_shift_right_iter;
  localparam int M = 8;
  logic i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0, i_arith = 1'b0;
  logic [M-1:0] i_argA = '0, i_argB = '0;
  logic [M-1:0] o_y;
  logic o_busy, o_done, ERROR;
  typedef struct {logic [M-1:0] y; logic e; int at;} exp_t;
  exp_t q[$];
  exp_t cur;
  int cyc = 0, checks = 0, errors = 0;
  shift_right_iter #(.M(M)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_argA(i_argA),
    .i_argB(i_argB), .i_arith(i_arith), .o_y(o_y), .o_busy(o_busy),
    .o_done(o_done), .ERROR(ERROR)
  );
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, act, req);
    end
  endtask
  // Monitor: every completion pulse must match the oldest pending expectation
  always @(negedge i_clk) if (o_done === 1'b1) begin
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done: o_done=1 at cycle %0d with no request pending, want 0", cyc);
    end else begin
      cur = q.pop_front();
      chk("y", o_y, cur.y);
      chk("error_flag", ERROR, cur.e);
      chk("done_cycle", cyc, cur.at);
      chk("busy_at_done", o_busy, 1);
    end
  end
  task automatic issue(input logic [M-1:0] a, input logic [M-1:0] b, input logic ar,
                       input logic [M-1:0] ey, input logic ee, input int lat);
    @(negedge i_clk);
    i_argA = a; i_argB = b; i_arith = ar; i_start = 1'b1;
    q.push_back('{ey, ee, cyc + lat});
    @(negedge i_clk);
    i_start = 1'b0; i_argA = ~a; i_argB = 8'h01; i_arith = ~ar;
    chk("busy_after_start", o_busy, 1);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge i_clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d results pending, want 0", q.size());
      q.delete();
    end
    @(negedge i_clk);
  endtask
  task automatic run(input logic [M-1:0] a, input logic [M-1:0] b, input logic ar,
                     input logic [M-1:0] ey, input logic ee, input int lat);
    issue(a, b, ar, ey, ee, lat);
    wait_idle();
    chk("y_hold", o_y, ey);
    chk("error_hold", ERROR, ee);
    chk("busy_idle", o_busy, 0);
  endtask
  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_y", o_y, 0);
    chk("rst_error", ERROR, 0);
    chk("rst_done", o_done, 0);
    chk("rst_busy", o_busy, 0);
    i_rst = 1'b0;
    run(8'hB0, 8'd3, 1'b0, 8'h16, 1'b0, 4);
    run(8'hB0, 8'd3, 1'b1, 8'hF6, 1'b0, 4);
    run(8'h5A, 8'd0, 1'b0, 8'h5A, 1'b0, 1);
    run(8'h5A, 8'hF0, 1'b0, 8'h00, 1'b1, 1);
    run(8'h80, 8'd12, 1'b1, 8'hFF, 1'b0, 9);
    run(8'h80, 8'd12, 1'b0, 8'h00, 1'b0, 9);
    run(8'hFF, 8'd1, 1'b0, 8'h7F, 1'b0, 2);
    run(8'h81, 8'd7, 1'b1, 8'hFF, 1'b0, 8);
    run(8'h81, 8'd8, 1'b0, 8'h00, 1'b0, 9);
    run(8'h7F, 8'h7F, 1'b1, 8'h00, 1'b0, 9);
    run(8'hC3, 8'd2, 1'b1, 8'hF0, 1'b0, 3);
    // reset in the middle of a B=5 shift: no completion, everything cleared
    @(negedge i_clk);
    i_argA = 8'hFF; i_argB = 8'd5; i_arith = 1'b0; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("busy_mid", o_busy, 1);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("abort_y", o_y, 0);
    chk("abort_error", ERROR, 0);
    chk("abort_done", o_done, 0);
    chk("abort_busy", o_busy, 0);
    i_rst = 1'b0;
    run(8'h04, 8'd2, 1'b0, 8'h01, 1'b0, 3);
    // start pulsed mid-run is ignored; result from the first operands
    issue(8'hB0, 8'd5, 1'b0, 8'h05, 1'b0, 6);
    @(negedge i_clk);
    i_argA = 8'hFF; i_argB = 8'd1; i_arith = 1'b1; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_idle();
    repeat (3) @(negedge i_clk);
    chk("no_queued_start", o_busy, 0);
    chk("y_after_ignored", o_y, 8'h05);
    // reset wins over a simultaneous start
    i_rst = 1'b1; i_start = 1'b1; i_argA = 8'hFF; i_argB = 8'd1;
    @(negedge i_clk);
    i_rst = 1'b0; i_start = 1'b0;
    chk("rst_prio_busy", o_busy, 0);
    chk("rst_prio_y", o_y, 0);
    @(negedge i_clk);
    chk("rst_prio_busy2", o_busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
